// File: rtl/zap_predecode_skid_pkg.sv
// Shared decode-constants for the fetch->sequencer skid stage:
// entry layout, entry width and valid-bit state encodings.
package zap_predecode_skid_pkg;

    localparam int ENTRY_W = 66;

    // Encoded as {skid_valid, out_valid}; 2'b10 is illegal.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

    typedef struct packed {
        logic        irq;
        logic        fiq;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    function automatic entry_t pack_entry(
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic        irq,
        input logic        fiq
    );
        entry_t e;
        e.irq   = irq;
        e.fiq   = fiq;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/zap_predecode_skid.sv
// Two-entry skid/hold register between fetch and the LDM/STM sequencer.
// OUT drives the sequencer; SKID absorbs the instruction in flight on a stall.
module zap_predecode_skid
    import zap_predecode_skid_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instruction,
    input  logic        i_instruction_valid,
    input  logic [31:0] i_pc,
    input  logic        i_irq,
    input  logic        i_fiq,
    input  logic        i_cpsr_i,
    input  logic        i_cpsr_f,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_issue_stall,
    input  logic        i_stall_from_decode,
    output logic [31:0] o_instruction,
    output logic        o_instruction_valid,
    output logic [31:0] o_pc,
    output logic        o_irq,
    output logic        o_fiq,
    output logic        o_stall_to_fetch
);

    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    logic        out_v_q, out_v_d;
    logic        skid_v_q, skid_v_d;
    logic        stall_q, stall_d;
    logic        hold;
    entry_t      in_e;
    skid_state_e state;

    always_comb begin
        hold  = i_data_stall | i_issue_stall | i_stall_from_decode;
        in_e  = pack_entry(i_instruction, i_pc,
                           i_irq & ~i_cpsr_i, i_fiq & ~i_cpsr_f);
        state = skid_state_e'({skid_v_q, out_v_q});

        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        stall_d  = stall_q;

        if (i_clear_from_writeback) begin
            out_d    = '0;
            out_v_d  = 1'b0;
            skid_d   = '0;
            skid_v_d = 1'b0;
            stall_d  = 1'b0;
        end else if (i_data_stall) begin
            // Memory stall freezes everything, including back-pressure.
        end else if (i_clear_from_alu) begin
            out_d    = '0;
            out_v_d  = 1'b0;
            skid_d   = '0;
            skid_v_d = 1'b0;
            stall_d  = 1'b0;
        end else begin
            if (!hold) begin
                if (skid_v_q) begin
                    out_d    = skid_q;
                    out_v_d  = 1'b1;
                    skid_d   = in_e;
                    skid_v_d = i_instruction_valid;
                end else begin
                    out_d    = in_e;
                    out_v_d  = i_instruction_valid;
                end
            end else if (i_instruction_valid) begin
                unique case (state)
                    ST_EMPTY: begin
                        out_d   = in_e;
                        out_v_d = 1'b1;
                    end
                    ST_ONE: begin
                        skid_d   = in_e;
                        skid_v_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            stall_d = skid_v_d | (hold & out_v_d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            stall_q  <= stall_d;
        end
    end

    assign o_instruction       = out_q.instr;
    assign o_pc                = out_q.pc;
    assign o_irq               = out_q.irq;
    assign o_fiq               = out_q.fiq;
    assign o_instruction_valid = out_v_q;
    assign o_stall_to_fetch    = stall_q;

endmodule

// File: tb/tb_zap_predecode_skid.sv
// Scoreboard bench for zap_predecode_skid: a queue-of-instructions model
// predicts each cycle's outputs; a monitor compares after every edge.
module tb_zap_predecode_skid;
    import zap_predecode_skid_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_instruction;
    logic        i_instruction_valid;
    logic [31:0] i_pc;
    logic        i_irq, i_fiq, i_cpsr_i, i_cpsr_f;
    logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic        i_issue_stall, i_stall_from_decode;
    logic [31:0] o_instruction;
    logic        o_instruction_valid;
    logic [31:0] o_pc;
    logic        o_irq, o_fiq, o_stall_to_fetch;

    zap_predecode_skid dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_instruction(i_instruction),
        .i_instruction_valid(i_instruction_valid),
        .i_pc(i_pc), .i_irq(i_irq), .i_fiq(i_fiq),
        .i_cpsr_i(i_cpsr_i), .i_cpsr_f(i_cpsr_f),
        .i_clear_from_writeback(i_clear_from_writeback),
        .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu),
        .i_issue_stall(i_issue_stall),
        .i_stall_from_decode(i_stall_from_decode),
        .o_instruction(o_instruction),
        .o_instruction_valid(o_instruction_valid),
        .o_pc(o_pc), .o_irq(o_irq), .o_fiq(o_fiq),
        .o_stall_to_fetch(o_stall_to_fetch)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic   valid;
        entry_t e;
        logic   stall;
        logic   clr;
        logic   rst;
    } exp_t;

    exp_t   exp_q[$];
    entry_t mq[$];
    logic   m_stall = 1'b0;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge i_clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("valid", 32'(o_instruction_valid), 32'(x.valid));
            chk("stall", 32'(o_stall_to_fetch), 32'(x.stall));
            if (x.valid) begin
                chk("instr", o_instruction, x.e.instr);
                chk("pc", o_pc, x.e.pc);
                chk("irq", 32'(o_irq), 32'(x.e.irq));
                chk("fiq", 32'(o_fiq), 32'(x.e.fiq));
            end else if (x.clr) begin
                chk("irq_clr", 32'(o_irq), 32'd0);
                chk("fiq_clr", 32'(o_fiq), 32'd0);
            end
            if (x.rst) begin
                chk("instr_rst", o_instruction, 32'd0);
                chk("pc_rst", o_pc, 32'd0);
            end
            chk("illegal_state", 32'(!dut.out_v_q && dut.skid_v_q), 32'd0);
        end
    end

    // Model: the stage is an ordered list of at most two instructions.
    task automatic tick();
        logic hold;
        exp_t x;
        hold = i_data_stall | i_issue_stall | i_stall_from_decode;
        if (mq.size() == 2 && hold) i_instruction_valid = 1'b0;
        x.clr = 1'b0;
        x.rst = 1'b0;
        if (i_reset || i_clear_from_writeback) begin
            mq.delete();
            m_stall = 1'b0;
            x.clr = 1'b1;
            x.rst = i_reset;
        end else if (i_data_stall) begin
        end else if (i_clear_from_alu) begin
            mq.delete();
            m_stall = 1'b0;
            x.clr = 1'b1;
        end else begin
            if (!hold && mq.size() > 0) void'(mq.pop_front());
            if (i_instruction_valid && mq.size() < 2)
                mq.push_back(pack_entry(i_instruction, i_pc,
                    i_irq & !i_cpsr_i, i_fiq & !i_cpsr_f));
            m_stall = (mq.size() == 2) || (hold && mq.size() > 0);
        end
        x.valid = mq.size() > 0;
        x.e     = x.valid ? mq[0] : '0;
        x.stall = m_stall;
        exp_q.push_back(x);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_reset = 0; i_instruction = 0; i_instruction_valid = 0; i_pc = 0;
        i_irq = 0; i_fiq = 0; i_cpsr_i = 0; i_cpsr_f = 0;
        i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
        i_issue_stall = 0; i_stall_from_decode = 0;
    endtask

    task automatic put(logic [31:0] ins, logic [31:0] pc);
        i_instruction = ins; i_pc = pc; i_instruction_valid = 1;
    endtask

    task automatic fill_full(logic [31:0] a, logic [31:0] b);
        idle(); put(a, 32'h300); tick();
        idle(); i_stall_from_decode = 1; put(b, 32'h304); tick();
    endtask

    initial begin
        idle();
        i_reset = 1;
        @(negedge i_clk);
        tick();
        tick();

        // Streaming
        for (int k = 0; k < 8; k++) begin
            idle(); put(32'hE1A00000 + k, 32'h100 + 4 * k); tick();
        end
        idle(); tick();

        // Decode stall with one instruction in flight
        idle(); put(32'hE8BD8001, 32'h140); tick();
        idle(); i_stall_from_decode = 1; put(32'hE3A01005, 32'h144); tick();
        idle(); i_stall_from_decode = 1; tick();
        idle(); i_stall_from_decode = 1; tick();
        idle(); tick();
        idle(); tick();
        idle(); tick();

        // Interrupt capture and masking
        idle(); put(32'hE1A00000, 32'h200); i_irq = 1; tick();
        idle(); put(32'hE1A00000, 32'h204); i_irq = 1; i_cpsr_i = 1; tick();
        idle(); put(32'hE1A00000, 32'h208); i_fiq = 1; tick();
        idle(); put(32'hE1A00000, 32'h20C); i_fiq = 1; i_cpsr_f = 1; tick();
        idle(); tick();

        // Data stall beats ALU clear
        fill_full(32'hE0800001, 32'hE0800002);
        idle(); i_data_stall = 1; i_clear_from_alu = 1; tick();
        idle(); i_clear_from_alu = 1; tick();
        idle(); tick();

        // Writeback flush while FULL and memory-stalled
        fill_full(32'hE0800003, 32'hE0800004);
        idle(); i_clear_from_writeback = 1; i_data_stall = 1; tick();
        idle(); put(32'hEAFFFFFE, 32'h400); tick();
        idle(); tick();

        // Reset mid-stall
        fill_full(32'hE0800005, 32'hE0800006);
        idle(); i_issue_stall = 1; i_reset = 1; tick();
        idle(); put(32'hE5901000, 32'h500); tick();
        idle(); tick();

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            idle();
            i_instruction_valid    = ($urandom % 4) != 0;
            i_instruction          = $urandom;
            i_pc                   = $urandom & 32'hFFFF_FFFC;
            i_irq                  = 1'($urandom);
            i_fiq                  = 1'($urandom);
            i_cpsr_i               = 1'($urandom);
            i_cpsr_f               = 1'($urandom);
            i_data_stall           = ($urandom % 8) == 0;
            i_issue_stall          = ($urandom % 6) == 0;
            i_stall_from_decode    = ($urandom % 4) == 0;
            i_clear_from_alu       = ($urandom % 25) == 0;
            i_clear_from_writeback = ($urandom % 40) == 0;
            i_reset                = ($urandom % 300) == 0;
            tick();
        end

        idle();
        tick();
        repeat (2) @(posedge i_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
